// File: rtl/frame_draw_scheduler.sv
// Per-frame plotter arbiter: erase pass, lane advance, draw pass, round-robin start lane.
// Optional watchdog on stuck plot jobs is built when SCHED_WATCHDOG_EN is defined.
module frame_draw_scheduler #(
    parameter int LANES   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic [LANES-1:0] lane_req,
    input  logic             plot_done,
    output logic [LANES-1:0] grant,
    output logic             phase,
    output logic             plot_start,
    output logic             advance,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       frame_count,
    output logic             timeout_err
);

    localparam int PW = $clog2(LANES);

    if (LANES < 2 || LANES > 8 || TIMEOUT < 1) begin : g_param_check
        $error("frame_draw_scheduler: LANES must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {StIdle, StArb, StWait} state_e;

    state_e           r_state;
    logic [LANES-1:0] r_mask;
    logic [LANES-1:0] r_pending;
    logic [LANES-1:0] r_grant;
    logic [PW-1:0]    r_rr_ptr;
    logic [7:0]       r_frame_count;
    logic             r_phase;
    logic             r_plot_start;
    logic             r_advance;
    logic             r_frame_done;
    logic             r_overrun;

    logic [LANES-1:0] w_sel;
    logic             w_found;
    logic             w_done;
    logic             w_wd_hit;
    logic             w_release;

    // First pending lane at or above rr_ptr, wrapping at LANES-1.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (!w_found && r_pending[j] && (j == (int'(r_rr_ptr) + i) % LANES)) begin
                    w_sel[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

    // A done pulse coinciding with our own start belongs to a previous job.
    assign w_done    = plot_done & ~r_plot_start;
    assign w_release = w_done | w_wd_hit;

`ifdef SCHED_WATCHDOG_EN
    localparam int WdW = $clog2(TIMEOUT + 1);

    logic [WdW-1:0] r_wd_cnt;
    logic           r_timeout_err;

    assign w_wd_hit    = (r_state == StWait) && (r_wd_cnt == WdW'(TIMEOUT - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_wd_hit & ~w_done;
            if (r_state != StWait) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end
`else
    assign w_wd_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= StIdle;
            r_mask        <= '0;
            r_pending     <= '0;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_frame_count <= '0;
            r_phase       <= 1'b0;
            r_plot_start  <= 1'b0;
            r_advance     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_plot_start <= 1'b0;
            r_advance    <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= tick && (r_state != StIdle);
            unique case (r_state)
                StIdle: begin
                    if (tick) begin
                        r_mask    <= lane_req;
                        r_pending <= lane_req;
                        r_phase   <= 1'b0;
                        r_state   <= StArb;
                    end
                end
                StArb: begin
                    if (w_found) begin
                        r_grant      <= w_sel;
                        r_plot_start <= 1'b1;
                        r_state      <= StWait;
                    end else if (!r_phase) begin
                        r_advance <= 1'b1;
                        r_pending <= r_mask;
                        r_phase   <= 1'b1;
                    end else begin
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                        r_rr_ptr      <= (r_rr_ptr == PW'(LANES - 1)) ? '0 : r_rr_ptr + 1'b1;
                        r_grant       <= '0;
                        r_state       <= StIdle;
                    end
                end
                StWait: begin
                    if (w_release) begin
                        r_pending <= r_pending & ~r_grant;
                        r_grant   <= '0;
                        r_state   <= StArb;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign grant       = r_grant;
    assign phase       = r_phase;
    assign plot_start  = r_plot_start;
    assign advance     = r_advance;
    assign frame_done  = r_frame_done;
    assign busy        = (r_state != StIdle);
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule
